// File: rtl/sc_sng_pair.sv
// Dual deterministic stochastic number generator: x, y streams of 2^WIDTH bits, counter vs bit-reversed counter.
// First bit one cycle after start is accepted; en=0 in RUN stalls the stream with x/y and cnt held.
module sc_sng_pair #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] px,
   input  logic [WIDTH-1:0] py,
   input  logic             en,
   output logic             x,
   output logic             y,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] px_q;
   logic [WIDTH-1:0] py_q;
   logic [1:0]       mode_q;
   logic [WIDTH-1:0] rx;
   logic [WIDTH-1:0] ry;
   logic             x_next;
   logic             y_next;

   // rx is the van der Corput sequence; ry selects the correlation partner.
   always_comb begin
      rx = '0;
      for (int i = 0; i < WIDTH; i++) rx[i] = cnt[WIDTH-1-i];
      case (mode_q)
         2'd1:    ry = rx;
         2'd2:    ry = ~rx;
         default: ry = cnt;
      endcase
      x_next = (px_q > rx);
      y_next = (py_q > ry);
   end

   assign busy = (state == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         px_q   <= '0;
         py_q   <= '0;
         mode_q <= '0;
         x      <= 1'b0;
         y      <= 1'b0;
         valid  <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               valid <= 1'b0;
               done  <= 1'b0;
               if (start) begin
                  px_q   <= px;
                  py_q   <= py;
                  mode_q <= mode;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (en) begin
                  x     <= x_next;
                  y     <= y_next;
                  valid <= 1'b1;
                  if (cnt == {WIDTH{1'b1}}) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     done <= 1'b0;
                     cnt  <= cnt + 1'b1;
                  end
               end else begin
                  valid <= 1'b0;
                  done  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sc_sng_pair.sv
// Randomized bench for sc_sng_pair against an arithmetic stream model and popcount laws.
module tb_sc_sng_pair;
   localparam int W = 4;
   localparam int N = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         en;
   logic [1:0]   mode;
   logic [W-1:0] px;
   logic [W-1:0] py;
   logic         x, y, valid, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   sc_sng_pair #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .px(px), .py(py),
      .en(en), .x(x), .y(y), .valid(valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: probability p compared with the k-th value of the chosen random source.
   function automatic logic exp_bit(input int k, input int p, input int m, input bit is_y);
      int rev = 0;
      int r;
      for (int b = 0; b < W; b++) rev += ((k >> b) & 1) * (1 << (W - 1 - b));
      if (!is_y)       r = rev;
      else if (m == 1) r = rev;
      else if (m == 2) r = N - 1 - rev;
      else             r = k;
      return (p > r);
   endfunction

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         en = $urandom_range(0, 1);
         tick();
         check("idle_valid", valid, 0);
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
      end
   endtask

   task automatic run_stream(input int p_x, input int p_y, input int m, input int en_pct,
                             input bit hold, input int abort_at,
                             output logic [N-1:0] xv, output logic [N-1:0] yv);
      int   k = 0, cyc = 0, cx = 0, cy = 0, cand = 0, cor = 0, ovl;
      logic xo, yo;
      xv = '0;
      yv = '0;
      start = 1'b1;
      px = W'(p_x);
      py = W'(p_y);
      mode = 2'(m);
      en = $urandom_range(0, 1);
      tick();
      check("start_busy", busy, 1);
      check("start_valid", valid, 0);
      if (!hold) start = 1'b0;
      while (k < N) begin
         if (cyc > 20 * N) begin
            check("timeout_bits", k, N);
            return;
         end
         cyc++;
         en   = ($urandom_range(0, 99) < en_pct);
         px   = W'($urandom_range(0, N - 1));
         py   = W'($urandom_range(0, N - 1));
         mode = 2'($urandom_range(0, 3));
         xo = x;
         yo = y;
         tick();
         if (en) begin
            check("valid", valid, 1);
            check("x", x, exp_bit(k, p_x, m, 0));
            check("y", y, exp_bit(k, p_y, m, 1));
            check("done", done, (k == N - 1));
            check("busy", busy, (k != N - 1));
            xv[k] = x;
            yv[k] = y;
            cx   += int'(x);
            cy   += int'(y);
            cand += int'(x & y);
            cor  += int'(x | y);
            if (k == abort_at) begin
               start = 1'b0;
               rst = 1'b1;
               #1;
               check("abort_x", x, 0);
               check("abort_y", y, 0);
               check("abort_valid", valid, 0);
               check("abort_busy", busy, 0);
               check("abort_done", done, 0);
               tick();
               check("abort_done_edge", done, 0);
               rst = 1'b0;
               return;
            end
            k++;
         end else begin
            check("stall_valid", valid, 0);
            check("stall_done", done, 0);
            check("stall_busy", busy, 1);
            check("stall_x", x, xo);
            check("stall_y", y, yo);
         end
      end
      check("pop_x", cx, p_x);
      check("pop_y", cy, p_y);
      ovl = (p_x + p_y > N) ? p_x + p_y - N : 0;
      if (m == 1) check("and_scc_pos", cand, (p_x < p_y) ? p_x : p_y);
      if (m == 2) begin
         check("and_scc_neg", cand, ovl);
         check("or_scc_neg", cor, p_x + p_y - ovl);
      end
   endtask

   initial begin
      logic [N-1:0] xv, yv;
      rst = 1'b1; start = 1'b0; en = 1'b0; mode = '0; px = '0; py = '0;
      tick();
      tick();
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      idle_cycles(2);

      // Uncorrelated pattern: rx = 0,8,4,12,2,... so px=5 hits k=0,2,4,8,12; ry=cnt so py=3 hits k=0..2.
      run_stream(5, 3, 0, 100, 0, -1, xv, yv);
      check("pattern_x", xv, 16'h1115);
      check("pattern_y", yv, 16'h0007);
      idle_cycles(1);

      run_stream(10, 6, 1, 100, 0, -1, xv, yv);
      run_stream(10, 6, 2, 100, 0, -1, xv, yv);
      run_stream(13, 9, 2, 100, 0, -1, xv, yv);
      run_stream(9, 4, 0, 50, 0, -1, xv, yv);
      run_stream(9, 12, 1, 50, 0, -1, xv, yv);

      run_stream(0, N - 1, 0, 70, 0, -1, xv, yv);
      check("zero_x", xv, 0);
      check("full_y", yv, 16'h7FFF);
      run_stream(N - 1, 7, 3, 100, 0, -1, xv, yv);
      check("full_x", xv, 16'h7FFF);

      run_stream(7, 12, 1, 100, 1, -1, xv, yv);
      run_stream(3, 14, 2, 60, 0, -1, xv, yv);
      idle_cycles(1);

      run_stream(11, 5, 0, 100, 0, 5, xv, yv);
      idle_cycles(2);
      run_stream(11, 5, 0, 100, 0, -1, xv, yv);

      for (int s = 0; s < 10; s++) begin
         run_stream($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, 3),
                    $urandom_range(30, 100), 1'($urandom_range(0, 1)), -1, xv, yv);
      end
      start = 1'b0;
      idle_cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
